// File: rtl/experiment3_adders_if.sv
// Operand/result bundle for the experiment3_adders lab block.
// The master drives operands and reads results; the block sits on the slave side.
interface experiment3_adders_if;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  M;
   logic [3:0]  N;
   logic        Cin;
   logic        X;
   logic        Y;
   logic        Sign;
   logic        flag;
   logic        halfadderout;
   logic        halfadderoutput;
   logic        fulladderout;
   logic        fulladderoutput;
   logic        fourbitadderout;
   logic [3:0]  fourbitoutput;
   logic        sixteenOut;
   logic [15:0] sixteenOutput;
   logic        sixteensubtOut;
   logic [15:0] sixteensubtOutput;
   logic        part7Out;
   logic [15:0] part7Output;

   // No handshake: operands are taken on every rising edge and each result
   // appears on the edge after its operands were sampled.
   modport master (
      output A, B, M, N, Cin, X, Y, Sign,
      input  flag, halfadderout, halfadderoutput, fulladderout, fulladderoutput,
             fourbitadderout, fourbitoutput, sixteenOut, sixteenOutput,
             sixteensubtOut, sixteensubtOutput, part7Out, part7Output
   );

   modport slave (
      input  A, B, M, N, Cin, X, Y, Sign,
      output flag, halfadderout, halfadderoutput, fulladderout, fulladderoutput,
             fourbitadderout, fourbitoutput, sixteenOut, sixteenOutput,
             sixteensubtOut, sixteensubtOutput, part7Out, part7Output
   );
endinterface

// File: rtl/experiment3_adders.sv
// Parallel half/full/4-bit/16-bit adders, subtractor and add/sub unit, all
// built from one full-adder cell, with every result registered (1-cycle latency).
module experiment3_adders_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module experiment3_adders_ripple #(
   parameter int W = 16
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);
   logic [W:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < W; g++) begin : g_cell
      experiment3_adders_fa u_fa (
         .i_a (i_a[g]),
         .i_b (i_b[g]),
         .i_c (w_c[g]),
         .o_s (o_sum[g]),
         .o_c (w_c[g+1])
      );
   end

   assign o_cout = w_c[W];
endmodule

module experiment3_adders (
   input  logic                  clk,
   input  logic                  rst,
   experiment3_adders_if.slave   bus
);
   logic        w_fa_s, w_fa_c;
   logic [3:0]  w_s4;
   logic        w_c4;
   logic [15:0] w_s16, w_ssub, w_sp7, w_bp7;
   logic        w_c16, w_csub, w_cp7;
   logic        w_cin_msb;

   experiment3_adders_fa u_full (
      .i_a (bus.X), .i_b (bus.Y), .i_c (bus.Cin), .o_s (w_fa_s), .o_c (w_fa_c)
   );

   experiment3_adders_ripple #(.W(4)) u_add4 (
      .i_a (bus.M), .i_b (bus.N), .i_cin (bus.Cin), .o_sum (w_s4), .o_cout (w_c4)
   );

   experiment3_adders_ripple #(.W(16)) u_add16 (
      .i_a (bus.A), .i_b (bus.B), .i_cin (1'b0), .o_sum (w_s16), .o_cout (w_c16)
   );

   experiment3_adders_ripple #(.W(16)) u_sub16 (
      .i_a (bus.A), .i_b (~bus.B), .i_cin (1'b1), .o_sum (w_ssub), .o_cout (w_csub)
   );

   assign w_bp7 = bus.B ^ {16{bus.Sign}};

   experiment3_adders_ripple #(.W(16)) u_part7 (
      .i_a (bus.A), .i_b (w_bp7), .i_cin (bus.Sign), .o_sum (w_sp7), .o_cout (w_cp7)
   );

   // Carry into the MSB cell, recovered from that cell's sum equation.
   assign w_cin_msb = bus.A[15] ^ w_bp7[15] ^ w_sp7[15];

   logic        r_flag, r_hc, r_hs, r_fc, r_fs, r_c4, r_c16, r_csub, r_cp7;
   logic [3:0]  r_s4;
   logic [15:0] r_s16, r_ssub, r_sp7;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flag <= 1'b0;
         r_hc   <= 1'b0;
         r_hs   <= 1'b0;
         r_fc   <= 1'b0;
         r_fs   <= 1'b0;
         r_c4   <= 1'b0;
         r_s4   <= 4'd0;
         r_c16  <= 1'b0;
         r_s16  <= 16'd0;
         r_csub <= 1'b0;
         r_ssub <= 16'd0;
         r_cp7  <= 1'b0;
         r_sp7  <= 16'd0;
      end else begin
         r_flag <= w_cin_msb ^ w_cp7;
         r_hc   <= bus.X & bus.Y;
         r_hs   <= bus.X ^ bus.Y;
         r_fc   <= w_fa_c;
         r_fs   <= w_fa_s;
         r_c4   <= w_c4;
         r_s4   <= w_s4;
         r_c16  <= w_c16;
         r_s16  <= w_s16;
         r_csub <= w_csub;
         r_ssub <= w_ssub;
         r_cp7  <= w_cp7;
         r_sp7  <= w_sp7;
      end
   end

   assign bus.flag              = r_flag;
   assign bus.halfadderout      = r_hc;
   assign bus.halfadderoutput   = r_hs;
   assign bus.fulladderout      = r_fc;
   assign bus.fulladderoutput   = r_fs;
   assign bus.fourbitadderout   = r_c4;
   assign bus.fourbitoutput     = r_s4;
   assign bus.sixteenOut        = r_c16;
   assign bus.sixteenOutput     = r_s16;
   assign bus.sixteensubtOut    = r_csub;
   assign bus.sixteensubtOutput = r_ssub;
   assign bus.part7Out          = r_cp7;
   assign bus.part7Output       = r_sp7;
endmodule

// File: tb/tb_experiment3_adders.sv
// Bench for experiment3_adders: directed table, random vectors checked against
// an arithmetic model, and reset sequences, through an expected-result queue.
module tb_experiment3_adders;
   localparam int RW = 61;

   logic clk = 1'b0;
   logic rst = 1'b1;

   experiment3_adders_if bus ();

   experiment3_adders dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]   a;
      logic [15:0]   b;
      logic [3:0]    m;
      logic [3:0]    n;
      logic          cin;
      logic          x;
      logic          y;
      logic          sign;
      logic [RW-1:0] exp;
      string         name;
   } vec_t;

   logic [RW-1:0] exp_q[$];
   string         name_q[$];
   int            n_vec  = 0;
   int            n_fail = 0;
   vec_t          vecs[10];

   // {flag, half c/s, full c/s, 4b c/sum, add c/sum, sub c/sum, part7 c/sum}
   function automatic logic [RW-1:0] pack(
      input logic f, input logic hc, input logic hs, input logic fc, input logic fs,
      input logic c4, input logic [3:0] s4, input logic c16, input logic [15:0] s16,
      input logic cs, input logic [15:0] ss, input logic cp, input logic [15:0] sp);
      return {f, hc, hs, fc, fs, c4, s4, c16, s16, cs, ss, cp, sp};
   endfunction

   function automatic vec_t mk(
      input string nm, input logic [15:0] a, input logic [15:0] b, input logic [3:0] m,
      input logic [3:0] n, input logic cin, input logic x, input logic y, input logic sign,
      input logic [RW-1:0] exp);
      vec_t v;
      v.name = nm; v.a = a; v.b = b; v.m = m; v.n = n;
      v.cin = cin; v.x = x; v.y = y; v.sign = sign; v.exp = exp;
      return v;
   endfunction

   // Plain integer arithmetic; overflow judged from operand/result sign bits.
   function automatic logic [RW-1:0] model(input vec_t v);
      int unsigned s1, s4, sa, ss;
      logic [15:0] r7;
      logic        c7, f, bneg;
      s1 = int'(v.x) + int'(v.y) + int'(v.cin);
      s4 = int'(v.m) + int'(v.n) + int'(v.cin);
      sa = int'(v.a) + int'(v.b);
      ss = int'(v.a) + (32'h0000_FFFF - int'(v.b)) + 1;
      r7 = v.sign ? ss[15:0] : sa[15:0];
      c7 = v.sign ? ss[16] : sa[16];
      bneg = v.sign ? ~v.b[15] : v.b[15];
      f = (v.a[15] == bneg) && (r7[15] != v.a[15]);
      return pack(f, v.x & v.y, v.x ^ v.y, s1[1], s1[0], s4[4], s4[3:0],
                  sa[16], sa[15:0], ss[16], ss[15:0], c7, r7);
   endfunction

   task automatic drive(input vec_t v, input logic rst_v, input logic [RW-1:0] exp);
      @(negedge clk);
      rst      = rst_v;
      bus.A    = v.a;
      bus.B    = v.b;
      bus.M    = v.m;
      bus.N    = v.n;
      bus.Cin  = v.cin;
      bus.X    = v.x;
      bus.Y    = v.y;
      bus.Sign = v.sign;
      exp_q.push_back(exp);
      name_q.push_back(v.name);
   endtask

   // Scoreboard: pop one expectation per edge, sampled just after the edge.
   logic [RW-1:0] act;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [RW-1:0] e;
         string         nm;
         act = {bus.flag, bus.halfadderout, bus.halfadderoutput, bus.fulladderout,
                bus.fulladderoutput, bus.fourbitadderout, bus.fourbitoutput,
                bus.sixteenOut, bus.sixteenOutput, bus.sixteensubtOut,
                bus.sixteensubtOutput, bus.part7Out, bus.part7Output};
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_vec++;
         if (act !== e) begin
           n_fail++;
           $display("FAIL %s: got %h expected %h", nm, act, e);
         end
      end
   end

   initial begin
      vec_t v;
      bus.A = '0; bus.B = '0; bus.M = '0; bus.N = '0;
      bus.Cin = 1'b0; bus.X = 1'b0; bus.Y = 1'b0; bus.Sign = 1'b0;

      vecs[0] = mk("t2", 16'd29, 16'd3, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0,
                   pack(0, 0, 0, 0, 0, 0, 4'd2, 0, 16'd32, 1, 16'd26, 0, 16'd32));
      vecs[1] = mk("t3", 16'd103, 16'd145, 4'd5, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1,
                   pack(0, 0, 1, 1, 0, 0, 4'd9, 0, 16'd248, 0, 16'hFFD6, 0, 16'hFFD6));
      vecs[2] = mk("t4", 16'd202, 16'd97, 4'd7, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0,
                   pack(0, 0, 1, 1, 0, 0, 4'd13, 0, 16'd299, 1, 16'd105, 0, 16'd299));
      vecs[3] = mk("t5", 16'd21, 16'd83, 4'd2, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1,
                   pack(0, 1, 0, 1, 0, 0, 4'd4, 0, 16'd104, 0, 16'hFFC2, 0, 16'hFFC2));
      vecs[4] = mk("pos_ovf", 16'h7FFF, 16'd1, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0,
                   pack(1, 1, 0, 1, 1, 1, 4'd15, 0, 16'h8000, 1, 16'h7FFE, 0, 16'h8000));
      vecs[5] = mk("wrap16", 16'hFFFF, 16'd1, 4'd8, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0,
                   pack(0, 0, 1, 0, 1, 1, 4'd0, 1, 16'h0000, 1, 16'hFFFE, 1, 16'h0000));
      vecs[6] = mk("neg_ovf", 16'h8000, 16'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1,
                   pack(1, 0, 0, 0, 1, 0, 4'd1, 0, 16'h8001, 1, 16'h7FFF, 1, 16'h7FFF));
      vecs[7] = mk("zero_sub", 16'd0, 16'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1,
                   pack(0, 0, 0, 0, 0, 0, 4'd0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0000));
      vecs[8] = mk("min_add", 16'h8000, 16'h8000, 4'd9, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0,
                   pack(1, 0, 1, 0, 1, 0, 4'd15, 1, 16'h0000, 1, 16'h0000, 1, 16'h0000));
      vecs[9] = mk("max4", 16'hFFFF, 16'hFFFF, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 1'b1,
                   pack(0, 1, 0, 1, 1, 1, 4'd15, 1, 16'hFFFE, 1, 16'h0000, 1, 16'h0000));

      // Reset held two edges with non-zero operands: all outputs must read 0.
      drive(vecs[8], 1'b1, '0);
      drive(vecs[9], 1'b1, '0);

      for (int i = 0; i < 10; i++) drive(vecs[i], 1'b0, vecs[i].exp);

      // Reset in mid-stream discards the in-flight operands, then recovers.
      drive(vecs[2], 1'b0, vecs[2].exp);
      v = vecs[3]; v.name = "rst_mid";
      drive(v, 1'b1, '0);
      drive(vecs[4], 1'b0, vecs[4].exp);

      for (int i = 0; i < 40; i++) begin
         v = mk("rand", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0);
         drive(v, 1'b0, model(v));
      end

      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
